// File: rtl/ahb_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_dmem_slave
// Brief    : AHB-Lite single-transfer data-memory slave with byte/half/word
//            writes, configurable read wait states and ERROR responses.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_dmem_slave #(
  parameter int DEPTH     = 1024,
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        D_HSEL,
  input  logic [31:0] D_HADDR,
  input  logic [1:0]  D_HTRANS,
  input  logic        D_HWRITE,
  input  logic [2:0]  D_HSIZE,
  input  logic [31:0] D_HWDATA,
  output logic [31:0] D_HRDATA,
  output logic        D_HREADY,
  output logic [1:0]  D_HRESP
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_WDATA = 3'd1;
  localparam logic [2:0] c_RWAIT = 3'd2;
  localparam logic [2:0] c_RDONE = 3'd3;
  localparam logic [2:0] c_ERR1  = 3'd4;
  localparam logic [2:0] c_ERR2  = 3'd5;

  localparam logic [1:0] c_NONSEQ = 2'b10;
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_ERROR  = 2'b01;

  // Last value of the wait counter before read data is presented.
  localparam logic [3:0] c_WAIT_LAST = (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [AW+1:0] r_addr;
  logic [1:0]    r_size;
  logic          r_write;
  logic [3:0]    r_cnt;
  logic [31:0]   r_hrdata;
  logic          r_hready;
  logic [1:0]    r_hresp;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_size_err;
  logic          w_align_err;
  logic          w_range_err;
  logic          w_err;
  logic [AW-1:0] w_rd_idx;
  logic [3:0]    w_be;
  logic          w_we;

  assign w_accept    = (r_state == c_IDLE) && D_HSEL && (D_HTRANS == c_NONSEQ);
  assign w_size_err  = (D_HSIZE > 3'd2);
  assign w_align_err = ((D_HSIZE == 3'd1) && D_HADDR[0]) ||
                       ((D_HSIZE == 3'd2) && (D_HADDR[1:0] != 2'b00));
  assign w_range_err = (D_HADDR[31:2] >= 30'(DEPTH));
  assign w_err       = w_size_err || w_align_err || w_range_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          if (w_err)               w_next = c_ERR1;
          else if (D_HWRITE)       w_next = c_WDATA;
          else if (READ_WAIT > 0)  w_next = c_RWAIT;
          else                     w_next = c_RDONE;
        end
      end
      c_RWAIT: if (r_cnt == c_WAIT_LAST) w_next = c_RDONE;
      c_ERR1:  w_next = c_ERR2;
      default: w_next = c_IDLE;
    endcase
  end

  // With no wait states the read is launched straight from the address phase.
  assign w_rd_idx = (r_state == c_IDLE) ? D_HADDR[AW+1:2] : r_addr[AW+1:2];

  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_addr[1:0];
      2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_we = (r_state == c_WDATA) && r_write;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_addr[AW+1:2]][8*i +: 8] <= D_HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_addr   <= '0;
      r_size   <= 2'd0;
      r_write  <= 1'b0;
      r_cnt    <= 4'd0;
      r_hready <= 1'b0;
      r_hresp  <= c_OKAY;
      r_hrdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= D_HADDR[AW+1:0];
        r_size  <= D_HSIZE[1:0];
        r_write <= D_HWRITE;
      end
      r_cnt    <= (r_state == c_RWAIT) ? r_cnt + 4'd1 : 4'd0;
      r_hready <= (w_next == c_WDATA) || (w_next == c_RDONE) || (w_next == c_ERR2);
      r_hresp  <= ((w_next == c_ERR1) || (w_next == c_ERR2)) ? c_ERROR : c_OKAY;
      r_hrdata <= (w_next == c_RDONE) ? r_mem[w_rd_idx] : 32'd0;
    end
  end

  assign D_HRDATA = r_hrdata;
  assign D_HREADY = r_hready;
  assign D_HRESP  = r_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_dmem_slave
// Brief    : Bench driving three slave builds (READ_WAIT 0/1/3) from one bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_dmem_slave;

  localparam logic [1:0] c_NS = 2'b10;

  typedef struct packed {
    logic        chkd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata [3];
  logic        hready [3];
  logic [1:0]  hresp  [3];

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int n_pass;
  int n_total;

  ahb_dmem_slave #(.DEPTH(1024), .READ_WAIT(0)) u_rw0 (
    .clk(clk), .rst_n(rst_n), .D_HSEL(hsel), .D_HADDR(haddr), .D_HTRANS(htrans),
    .D_HWRITE(hwrite), .D_HSIZE(hsize), .D_HWDATA(hwdata),
    .D_HRDATA(hrdata[0]), .D_HREADY(hready[0]), .D_HRESP(hresp[0]));

  ahb_dmem_slave #(.DEPTH(1024), .READ_WAIT(1)) u_rw1 (
    .clk(clk), .rst_n(rst_n), .D_HSEL(hsel), .D_HADDR(haddr), .D_HTRANS(htrans),
    .D_HWRITE(hwrite), .D_HSIZE(hsize), .D_HWDATA(hwdata),
    .D_HRDATA(hrdata[1]), .D_HREADY(hready[1]), .D_HRESP(hresp[1]));

  ahb_dmem_slave #(.DEPTH(1024), .READ_WAIT(3)) u_rw3 (
    .clk(clk), .rst_n(rst_n), .D_HSEL(hsel), .D_HADDR(haddr), .D_HTRANS(htrans),
    .D_HWRITE(hwrite), .D_HSIZE(hsize), .D_HWDATA(hwdata),
    .D_HRDATA(hrdata[2]), .D_HREADY(hready[2]), .D_HRESP(hresp[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rw_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic int sb_size(input int k);
    return (k == 0) ? sb0.size() : (k == 1) ? sb1.size() : sb2.size();
  endfunction

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output exp_t e);
    case (k)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transfer: address phase, then `window` sampled cycles checked on all builds.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] exp_data, input logic err,
                      input logic sel, input logic [1:0] trans, input logic busy,
                      input int rst_at, input int window, input string name);
    int   lat [3];
    logic live;
    logic in_rst;
    logic exp_rdy;
    exp_t e;
    live = sel && (trans == c_NS);
    @(posedge clk); #1;
    hsel = sel; htrans = trans; haddr = addr; hwrite = wr; hsize = size;
    for (int k = 0; k < 3; k++) begin
      lat[k] = err ? 2 : wr ? 1 : rw_of(k) + 1;
      if (live && (rst_at == 0 || lat[k] <= rst_at)) begin
        e.chkd = err || !wr;
        e.resp = err ? 2'b01 : 2'b00;
        e.data = (err || wr) ? 32'd0 : exp_data;
        sb_push(k, e);
      end
    end
    for (int c = 1; c <= window; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        hsel = busy; htrans = busy ? c_NS : 2'b00; haddr = busy ? 32'h200 : 32'h0;
        hwrite = busy; hsize = 3'd2; hwdata = wdata;
      end
      if (c == 2) begin
        hsel = 1'b0; htrans = 2'b00;
        if (busy) hwdata = 32'hBAD0BAD0;
      end
      in_rst = (rst_at != 0) && (c > rst_at);
      for (int k = 0; k < 3; k++) begin
        exp_rdy = live && !in_rst && (c == lat[k]);
        chk($sformatf("%s ready d%0d c%0d", name, k, c), 32'(hready[k]), 32'(exp_rdy));
        if (hready[k] === 1'b1 && sb_size(k) > 0) begin
          sb_pop(k, e);
          chk($sformatf("%s resp d%0d", name, k), 32'(hresp[k]), 32'(e.resp));
          if (e.chkd) chk($sformatf("%s rdata d%0d", name, k), hrdata[k], e.data);
        end else if (hready[k] !== 1'b1) begin
          chk($sformatf("%s idle_rdata d%0d c%0d", name, k, c), hrdata[k], 32'd0);
          chk($sformatf("%s idle_resp d%0d c%0d", name, k, c), 32'(hresp[k]),
              (live && err && c == 1 && !in_rst) ? 32'd1 : 32'd0);
        end
      end
      if (c == rst_at) begin
        #1 rst_n = 1'b0;
      end
      if (rst_at != 0 && c == rst_at + 1) rst_n = 1'b1;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s pending d%0d", name, k), 32'(sb_size(k)), 32'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = 32'h0;
    hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset ready d%0d", k), 32'(hready[k]), 32'd0);
      chk($sformatf("reset resp d%0d", k), 32'(hresp[k]), 32'd0);
      chk($sformatf("reset rdata d%0d", k), hrdata[k], 32'd0);
    end
    rst_n = 1'b1;

    // Word write then back-to-back read of the same word.
    xfer(1, 32'h100, 3'd2, 32'hDEADBEEF, 0, 0, 1, c_NS, 0, 0, 1, "w100");
    xfer(0, 32'h100, 3'd2, 32'h0, 32'hDEADBEEF, 0, 1, c_NS, 0, 0, 6, "r100");

    // Sub-word lanes.
    xfer(1, 32'h100, 3'd2, 32'h11223344, 0, 0, 1, c_NS, 0, 0, 1, "w100b");
    xfer(1, 32'h101, 3'd0, 32'h0000AA00, 0, 0, 1, c_NS, 0, 0, 1, "wbyte");
    xfer(1, 32'h102, 3'd1, 32'h55660000, 0, 0, 1, c_NS, 0, 0, 1, "whalf");
    xfer(0, 32'h100, 3'd2, 32'h0, 32'h5566AA44, 0, 1, c_NS, 0, 0, 6, "rlanes");

    // Error responses leave RAM untouched.
    xfer(1, 32'h0, 3'd2, 32'hCAFEF00D, 0, 0, 1, c_NS, 0, 0, 1, "w0");
    xfer(1, 32'h103, 3'd1, 32'hFFFFFFFF, 0, 1, 1, c_NS, 0, 0, 6, "ehalf");
    xfer(0, 32'h102, 3'd2, 32'h0, 0, 1, 1, c_NS, 0, 0, 6, "eword");
    xfer(0, 32'h100, 3'd3, 32'h0, 0, 1, 1, c_NS, 0, 0, 6, "esize");
    xfer(0, 32'h1000, 3'd2, 32'h0, 0, 1, 1, c_NS, 0, 0, 6, "erange_r");
    xfer(1, 32'h1000, 3'd2, 32'h0BADBAD0, 0, 1, 1, c_NS, 0, 0, 6, "erange_w");
    xfer(1, 32'h101, 3'd2, 32'hEEEEEEEE, 0, 1, 1, c_NS, 0, 0, 6, "ealign_w");
    xfer(0, 32'h100, 3'd2, 32'h0, 32'h5566AA44, 0, 1, c_NS, 0, 0, 6, "r100_post_err");
    xfer(0, 32'h0, 3'd2, 32'h0, 32'hCAFEF00D, 0, 1, c_NS, 0, 0, 6, "r0_post_err");

    // Unselected or non-NONSEQ requests are ignored.
    xfer(1, 32'h0, 3'd2, 32'h99999999, 0, 0, 0, c_NS, 0, 0, 4, "nosel");
    xfer(1, 32'h0, 3'd2, 32'h88888888, 0, 0, 1, 2'b11, 0, 0, 4, "seq");
    xfer(1, 32'h0, 3'd2, 32'h77777777, 0, 0, 1, 2'b01, 0, 0, 4, "busytr");
    xfer(0, 32'h0, 3'd2, 32'h0, 32'hCAFEF00D, 0, 1, c_NS, 0, 0, 6, "r0_post_ign");

    // NONSEQ while a read is in flight is dropped.
    xfer(1, 32'h200, 3'd2, 32'h12345678, 0, 0, 1, c_NS, 0, 0, 1, "w200");
    xfer(0, 32'h100, 3'd2, 32'h0, 32'h5566AA44, 0, 1, c_NS, 1, 0, 6, "rbusy");
    xfer(0, 32'h200, 3'd2, 32'h0, 32'h12345678, 0, 1, c_NS, 0, 0, 6, "r200");

    // Reset mid-transfer.
    xfer(0, 32'h100, 3'd2, 32'h0, 32'h5566AA44, 0, 1, c_NS, 0, 1, 6, "rrst");
    xfer(0, 32'h100, 3'd2, 32'h0, 32'h5566AA44, 0, 1, c_NS, 0, 0, 6, "r_after_rst");
    xfer(1, 32'h300, 3'd2, 32'h11111111, 0, 0, 1, c_NS, 0, 0, 1, "w300");
    xfer(1, 32'h300, 3'd2, 32'h22222222, 0, 0, 1, c_NS, 0, 1, 6, "wrst");
    xfer(0, 32'h300, 3'd2, 32'h0, 32'h11111111, 0, 1, c_NS, 0, 0, 6, "r300");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
